// File: rtl/pll_reset_pkg.sv
// Shared definitions for the PLL reset / power-up sequencer.
// Holds the sequencer state encoding, the 81 MHz default timing
// constants and a small saturating-increment helper.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RAM_RST   = 3'd2,
    S_RAM_WAIT  = 3'd3,
    S_RUN       = 3'd4
  } seq_state_t;

  // Defaults for an 81 MHz logic clock.
  localparam int LOCK_FILT_DEF   = 1024;
  localparam int RAM_RST_CYC_DEF = 20;     // >= 200 ns
  localparam int RAM_VCS_CYC_DEF = 12150;  // 150 us
  localparam int CNT_W_DEF       = 14;

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flops to 0
//   d     - asynchronous input
//   q     - synchronized output (2 clk edges of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage shift register; the first stage may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// Reset and power-up sequencer downstream of the PLL wrapper.
// Filters PLL lock, holds the HyperRAM in reset, waits out its power-up
// time, then releases the system reset. Re-sequences on lock loss and
// keeps debug information about lock losses.
// Ports:
//   clk        - PLL logic clock
//   rst_n      - asynchronous active-low reset
//   pll_lock   - PLL lock, asynchronous to clk
//   sys_rst_n  - system reset, active-low, registered
//   ram_rst_n  - HyperRAM RESET#, registered
//   ram_ready  - HyperRAM controller may issue commands
//   lock_lost  - sticky: lock lost after the filter passed
//   lock_drops - saturating count of lock-loss events
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int LOCK_FILT   = LOCK_FILT_DEF,
  parameter int RAM_RST_CYC = RAM_RST_CYC_DEF,
  parameter int RAM_VCS_CYC = RAM_VCS_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       sys_rst_n,
  output logic       ram_rst_n,
  output logic       ram_ready,
  output logic       lock_lost,
  output logic [7:0] lock_drops
);

  localparam logic [CNT_W-1:0] LF_LAST  = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(RAM_RST_CYC - 1);
  localparam logic [CNT_W-1:0] VCS_LAST = CNT_W'(RAM_VCS_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             lock_s;
  seq_state_t       state;
  seq_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             drop;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Next-state and counter logic. Lock loss is tested before terminal
  // count so that it wins when both happen on the same edge.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    drop       = 1'b0;
    case (state)
      S_RESET: begin
        state_next = S_WAIT_LOCK;
        cnt_next   = '0;
      end
      S_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_next = '0;
        end else if (cnt == LF_LAST) begin
          state_next = S_RAM_RST;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      S_RAM_RST: begin
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
          drop       = 1'b1;
        end else if (cnt == RR_LAST) begin
          state_next = S_RAM_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      S_RAM_WAIT: begin
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
          drop       = 1'b1;
        end else if (cnt == VCS_LAST) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
          drop       = 1'b1;
        end else begin
          cnt_next = '0;
        end
      end
      default: begin
        state_next = S_RESET;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and outputs share one flop stage; outputs decode the
  // next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RESET;
      cnt        <= '0;
      sys_rst_n  <= 1'b0;
      ram_rst_n  <= 1'b0;
      ram_ready  <= 1'b0;
      lock_lost  <= 1'b0;
      lock_drops <= 8'd0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      ram_rst_n <= (state_next == S_RAM_WAIT) || (state_next == S_RUN);
      sys_rst_n <= (state_next == S_RUN);
      ram_ready <= (state_next == S_RUN);
      if (drop) begin
        lock_lost  <= 1'b1;
        lock_drops <= sat_inc8(lock_drops);
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq with small timing parameters.
// The reference model tracks how many consecutive synchronized
// lock-high samples have been seen since sequencing (re)started; output
// levels and loss events follow from that number alone.
module tb_pll_reset_seq;

  localparam int F = 8;
  localparam int R = 4;
  localparam int V = 20;
  localparam int W = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       sys_rst_n;
  logic       ram_rst_n;
  logic       ram_ready;
  logic       lock_lost;
  logic [7:0] lock_drops;

  pll_reset_seq #(
    .LOCK_FILT   (F),
    .RAM_RST_CYC (R),
    .RAM_VCS_CYC (V),
    .CNT_W       (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .sys_rst_n  (sys_rst_n),
    .ram_rst_n  (ram_rst_n),
    .ram_ready  (ram_ready),
    .lock_lost  (lock_lost),
    .lock_drops (lock_drops)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit m_started;
  int m_seq;
  int m_drops;
  bit m_lost;
  bit m_s1;
  bit m_s2;

  int e_ls;
  int e_ram;
  int e_sys;
  int e_rdy;
  int e_low;
  int guard;
  int drops_before;
  bit sys_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_seq     = 0;
    m_drops   = 0;
    m_lost    = 1'b0;
    m_s1      = 1'b0;
    m_s2      = 1'b0;
  endtask

  task automatic model_edge(input logic lk);
    bit ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = lk;
    if (!m_started) begin
      m_started = 1'b1;
      m_seq     = 0;
    end else if (ls) begin
      if (m_seq < 100000) m_seq++;
    end else begin
      if (m_seq >= F) begin
        m_lost = 1'b1;
        if (m_drops < 255) m_drops++;
      end
      m_seq = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_ram_rst_n"}, {31'd0, ram_rst_n}, {31'd0, m_started && (m_seq >= F + R)});
    chk({tag, "_sys_rst_n"}, {31'd0, sys_rst_n}, {31'd0, m_started && (m_seq >= F + R + V)});
    chk({tag, "_ram_ready"}, {31'd0, ram_ready}, {31'd0, m_started && (m_seq >= F + R + V)});
    chk({tag, "_lock_lost"}, {31'd0, lock_lost}, {31'd0, m_lost});
    chk({tag, "_lock_drops"}, {24'd0, lock_drops}, m_drops);
  endtask

  // One clock cycle: drive lock, take the edge, check 1 time unit later,
  // return at the following falling edge.
  task automatic cyc(input logic lk);
    pll_lock = lk;
    @(posedge clk);
    model_edge(lk);
    #1;
    check_outputs("cyc");
    @(negedge clk);
  endtask

  // Assert reset between edges, check outputs drop with no clock edge,
  // hold for a cycle and release at a falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    check_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // 1. normal bring-up
    e_ls = -1; e_ram = -1; e_sys = -1; e_rdy = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1);
      if (e_ls  < 0 && dut.lock_s === 1'b1) e_ls  = i;
      if (e_ram < 0 && ram_rst_n  === 1'b1) e_ram = i;
      if (e_sys < 0 && sys_rst_n  === 1'b1) e_sys = i;
      if (e_rdy < 0 && ram_ready  === 1'b1) e_rdy = i;
    end
    chk("t1_lock_s_latency", e_ls, 2);
    chk("t1_ram_rst_rise", e_ram, 2 + F + R);
    chk("t1_sys_rst_rise", e_sys, 2 + F + R + V);
    chk("t1_ram_ready_rise", e_rdy, 2 + F + R + V);
    chk("t1_lock_lost", {31'd0, lock_lost}, 32'd0);
    chk("t1_lock_drops", {24'd0, lock_drops}, 32'd0);

    // 3. lock loss in S_RUN
    e_low = -1;
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0);
      if (e_low < 0 && sys_rst_n === 1'b0 && ram_rst_n === 1'b0 && ram_ready === 1'b0) e_low = i;
    end
    chk("t3_outputs_low_edge", e_low, 3);
    chk("t3_lock_lost", {31'd0, lock_lost}, 32'd1);
    chk("t3_lock_drops", {24'd0, lock_drops}, 32'd1);
    e_sys = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1);
      if (e_sys < 0 && sys_rst_n === 1'b1) e_sys = i;
    end
    chk("t3_resequence", e_sys, 2 + F + R + V);

    // 2. filter glitch after 6 samples
    do_reset();
    e_ram = -1;
    for (int i = 1; i <= 30; i++) begin
      cyc((i == 7) ? 1'b0 : 1'b1);
      if (e_ram < 0 && ram_rst_n === 1'b1) e_ram = i;
    end
    chk("t2_ram_rst_rise", e_ram, 9 + F + R);
    chk("t2_lock_drops", {24'd0, lock_drops}, 32'd0);

    // 4. reset mid S_RAM_WAIT at cnt = 10
    do_reset();
    guard = 0;
    while (m_seq != F + R + 10 && guard < 60) begin
      cyc(1'b1);
      guard++;
    end
    chk("t4_cnt_at_10", {27'd0, dut.cnt}, 32'd10);
    chk("t4_ram_hi_before", {31'd0, ram_rst_n}, 32'd1);
    do_reset();
    cyc(1'b1);
    chk("t4_cnt_restart", {27'd0, dut.cnt}, 32'd0);
    e_ram = -1;
    for (int i = 2; i <= 20; i++) begin
      cyc(1'b1);
      if (e_ram < 0 && ram_rst_n === 1'b1) e_ram = i;
    end
    chk("t4_ram_rst_rise", e_ram, 2 + F + R);

    // 6. loss on the terminal-count edge in S_RAM_WAIT
    do_reset();
    guard = 0;
    while (m_seq != F + R + V - 3 && guard < 60) begin
      cyc(1'b1);
      guard++;
    end
    drops_before = lock_drops;
    sys_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0);
      if (sys_rst_n !== 1'b0) sys_seen = 1'b1;
    end
    chk("t6_sys_never_rose", {31'd0, sys_seen}, 32'd0);
    chk("t6_lock_drops", {24'd0, lock_drops}, drops_before + 1);
    chk("t6_state_wait_lock", {29'd0, dut.state}, 32'd1);

    // randomized lock activity against the model
    do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      logic lv;
      int len;
      lv  = logic'($urandom_range(0, 3) != 0);
      len = lv ? $urandom_range(1, 45) : $urandom_range(1, 4);
      for (int k = 0; k < len; k++) cyc(lv);
    end

    // 5. drop counter saturation
    do_reset();
    for (int ev = 0; ev < 260; ev++) begin
      guard = 0;
      while (m_seq < F && guard < 40) begin
        cyc(1'b1);
        guard++;
      end
      for (int k = 0; k < 3; k++) cyc(1'b0);
    end
    chk("t5_drops_saturated", {24'd0, lock_drops}, 32'd255);
    for (int k = 0; k < 20; k++) cyc(1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0);
    chk("t5_drops_hold", {24'd0, lock_drops}, 32'd255);
    chk("t5_lock_lost", {31'd0, lock_lost}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
